// File: rtl/ghost_mode_scheduler_if.sv
// Mode bus between the game control and the ghost mode scheduler.
// The master drives the game-state inputs; the slave drives the ghost mode outputs.
interface ghost_mode_scheduler_if;
  logic       start;
  logic       pause;
  logic       energizer;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       fright_warn;
  logic       reverse;
  logic [2:0] phase;

  modport master (
    output start, pause, energizer,
    input  isScatter, isChase, isFrightened, fright_warn, reverse, phase
  );

  modport slave (
    input  start, pause, energizer,
    output isScatter, isChase, isFrightened, fright_warn, reverse, phase
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global scatter/chase schedule with frightened overlay, shared by all ghosts.
// Outputs are registered and change one cycle after the causing tick or pulse.
module ghost_mode_scheduler #(
  parameter int TICK_DIV   = 25_000_000,
  parameter int SCAT_SEC0  = 7,
  parameter int SCAT_SEC1  = 7,
  parameter int SCAT_SEC2  = 5,
  parameter int SCAT_SEC3  = 5,
  parameter int CHASE_SEC  = 20,
  parameter int FRIGHT_SEC = 6,
  parameter int WARN_SEC   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  ghost_mode_scheduler_if.slave   bus
);

  // state   | meaning
  // IDLE    | game not running, all modes off
  // SCATTER | even schedule phase, ghosts head to corners
  // CHASE   | odd schedule phase, ghosts pursue Pac-Man
  // FRIGHT  | energizer overlay, schedule frozen
  typedef enum logic [1:0] {IDLE, SCATTER, CHASE, FRIGHT} state_t;

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [7:0]       FRIGHT_LAST = 8'(FRIGHT_SEC - 1);
  localparam logic [7:0]       WARN_TH     = 8'(FRIGHT_SEC - WARN_SEC);

  // {isScatter, isChase, isFrightened}
  localparam logic [2:0] M_OFF    = 3'b000;
  localparam logic [2:0] M_SCAT   = 3'b100;
  localparam logic [2:0] M_CHASE  = 3'b010;
  localparam logic [2:0] M_FRIGHT = 3'b001;

  state_t           state;
  logic             saved_chase;
  logic [CNT_W-1:0] sec_cnt;
  logic [7:0]       phase_sec;
  logic [7:0]       fright_sec;
  logic             sec_tick;

  assign sec_tick = (sec_cnt == CNT_LAST);

  function automatic logic [7:0] dur(input logic [2:0] p);
    case (p)
      3'd0:    dur = 8'(SCAT_SEC0);
      3'd2:    dur = 8'(SCAT_SEC1);
      3'd4:    dur = 8'(SCAT_SEC2);
      3'd6:    dur = 8'(SCAT_SEC3);
      default: dur = 8'(CHASE_SEC);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      saved_chase     <= 1'b0;
      sec_cnt         <= '0;
      phase_sec       <= '0;
      fright_sec      <= '0;
      bus.phase       <= '0;
      bus.reverse     <= 1'b0;
      bus.fright_warn <= 1'b0;
      {bus.isScatter, bus.isChase, bus.isFrightened} <= M_OFF;
    end else if (!bus.start) begin
      state           <= IDLE;
      saved_chase     <= 1'b0;
      sec_cnt         <= '0;
      phase_sec       <= '0;
      fright_sec      <= '0;
      bus.phase       <= '0;
      bus.reverse     <= 1'b0;
      bus.fright_warn <= 1'b0;
      {bus.isScatter, bus.isChase, bus.isFrightened} <= M_OFF;
    end else if (bus.pause) begin
      // Everything holds except the reverse pulse, which must not outlive its cycle.
      bus.reverse <= 1'b0;
    end else begin
      bus.reverse <= 1'b0;
      sec_cnt     <= sec_tick ? '0 : sec_cnt + 1'b1;
      case (state)
        IDLE: begin
          state      <= SCATTER;
          sec_cnt    <= '0;
          phase_sec  <= '0;
          fright_sec <= '0;
          bus.phase  <= '0;
          {bus.isScatter, bus.isChase, bus.isFrightened} <= M_SCAT;
        end
        SCATTER, CHASE: begin
          if (bus.energizer) begin
            saved_chase     <= (state == CHASE);
            state           <= FRIGHT;
            fright_sec      <= '0;
            sec_cnt         <= '0;
            bus.reverse     <= 1'b1;
            bus.fright_warn <= 1'b0;
            {bus.isScatter, bus.isChase, bus.isFrightened} <= M_FRIGHT;
          end else if (sec_tick && bus.phase != 3'd7) begin
            if (phase_sec == dur(bus.phase) - 8'd1) begin
              phase_sec   <= '0;
              bus.phase   <= bus.phase + 3'd1;
              bus.reverse <= 1'b1;
              if (state == SCATTER) begin
                state <= CHASE;
                {bus.isScatter, bus.isChase, bus.isFrightened} <= M_CHASE;
              end else begin
                state <= SCATTER;
                {bus.isScatter, bus.isChase, bus.isFrightened} <= M_SCAT;
              end
            end else begin
              phase_sec <= phase_sec + 8'd1;
            end
          end
        end
        FRIGHT: begin
          if (bus.energizer) begin
            fright_sec      <= '0;
            sec_cnt         <= '0;
            bus.reverse     <= 1'b1;
            bus.fright_warn <= 1'b0;
          end else if (sec_tick) begin
            if (fright_sec == FRIGHT_LAST) begin
              fright_sec      <= '0;
              bus.fright_warn <= 1'b0;
              if (saved_chase) begin
                state <= CHASE;
                {bus.isScatter, bus.isChase, bus.isFrightened} <= M_CHASE;
              end else begin
                state <= SCATTER;
                {bus.isScatter, bus.isChase, bus.isFrightened} <= M_SCAT;
              end
            end else begin
              fright_sec      <= fright_sec + 8'd1;
              bus.fright_warn <= (fright_sec + 8'd1 >= WARN_TH);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
